axi_pim_banked_slave: RTL and testbench
=======================================

// Module: axi_pim_banked_slave
//
// PURPOSE
// AXI4 slave fronting NUM_BANKS PIM operand/result memories; generalises the fixed 32x32 two-memory top.
// Full burst support (FIXED/INCR/WRAP, up to 256 beats), byte strobes, SLVERR signalling.
// Independent read and write engines. Sits between the SoC interconnect and the PIM array operand banks.
//
// PARAMETERS
// DATA_WIDTH   32   AXI data width in bits (32, 64 or 128)
// ADDR_WIDTH   16   AXI byte-address width
// STRB_WIDTH   DATA_WIDTH/8   strobe width (derived, do not override)
// ID_WIDTH     8    AXI ID width
// NUM_BANKS    2    memory banks, power of two, >=1
// WORD_BITS    ADDR_WIDTH-$clog2(STRB_WIDTH)   word-index width (derived)
// BANK_DEPTH   2**(WORD_BITS-$clog2(NUM_BANKS))   words per bank (derived)
//
// PORTS
// clock          in   1   sole clock, all logic on posedge
// reset          in   1   asynchronous, active-high
// s_axi_aw*      in   AXI4  awid/awaddr/awlen[8]/awsize[3]/awburst[2]/awlock/awcache/awprot/awvalid
// s_axi_awready  out  1   write-address accept
// s_axi_w*       in   AXI4  wdata[DATA_WIDTH]/wstrb[STRB_WIDTH]/wlast/wvalid
// s_axi_wready   out  1   write-data accept
// s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1   write response; s_axi_bready in 1
// s_axi_ar*      in   AXI4  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid
// s_axi_arready  out  1   read-address accept
// s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_axi_rready in 1
//
// BEHAVIOUR
// - Reset: all ready/valid outputs 0, bid/rid/rdata/bresp/rresp/rlast 0, FSMs to IDLE; awready/arready rise 1st cycle after deassert.
//   Reset mid-burst aborts it; bank contents are not reset. Lock/cache/prot ignored.
// - Map: word = addr[ADDR_WIDTH-1:$clog2(STRB_WIDTH)]; bank = top $clog2(NUM_BANKS) bits of word; row = remaining bits.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. awready=1 only in W_IDLE; AW handshake latches id/addr/len/size/burst.
//   wready=1 in W_DATA; each W handshake writes bytes where wstrb=1, then address advances. After beat awlen, go W_RESP;
//   bvalid asserts next cycle, held with bid/bresp until bready; awready returns cycle after B handshake.
// - wlast mismatch vs beat counter: counter governs completion, bresp=SLVERR.
// - Read FSM R_IDLE->R_DATA->R_IDLE. arready=1 only in R_IDLE; first rvalid 1 cycle after AR handshake (registered read).
//   rready held high -> one beat/cycle; rvalid&&!rready holds rdata/rlast/rresp stable. rlast on beat arlen; R_IDLE after it.
// - Next address: FIXED unchanged; INCR +(1<<size), wraps modulo 2**ADDR_WIDTH; WRAP within aligned (len+1)<<size window.
// - Errors (SLVERR=2'b10): size>$clog2(STRB_WIDTH), burst=2'b11, WRAP with len not in {1,3,7,15}.
//   Errored bursts still consume all beats: writes suppressed, reads return 0 with SLVERR every beat. OKAY=2'b00 otherwise.
// - Narrow (size<bus): writes honour wstrb only; reads return the full word.
// - Simultaneous read and write to same word same cycle: read returns old data (read-before-write).
// - One outstanding transaction per direction; no reordering.
//
// STRUCTURE
// - Package axi_pim_pkg: burst enum (FIXED/INCR/WRAP), resp constants OKAY/SLVERR, wstate/rstate enums,
//   function legal_burst(len,size,burst).
// - Sub-module axi_burst_addr_gen (addr,len,size,burst -> next_addr), instantiated once per channel.
// - Banks: array mem[NUM_BANKS][BANK_DEPTH], per-byte write enables.
//
// TESTING
// - INCR write len=3 size=2 @0x0010 data 0x11111111..0x44444444 -> words 4..7 written, bresp=OKAY, bid echoed.
// - WRAP read len=3 @0x001C after above -> rdata 0x44444444,0x11111111,0x22222222,0x33333333, rlast on 4th.
// - wstrb=4'b0101 data 0xAABBCCDD over 0x00000000 -> word reads 0x00BB00DD.
// - NUM_BANKS=4: write 0xCAFEF00D @0xC000 -> mem[3][0]; same addr read returns it; mem[0][0] unchanged.
// - awsize=3 on 32-bit bus, len=1 -> no writes, bresp=SLVERR; arburst=2'b11 -> two beats rdata=0 rresp=SLVERR.
// - rready toggled 1/0 during INCR len=7 read; reset asserted mid-write burst -> rdata stable while stalled; all valids 0, next AW accepted.

Source files
------------

// File: rtl/axi_pim_pkg.sv
// Shared types for the banked PIM AXI4 slave: burst encodings, response codes,
// engine state enums and the burst legality check used by both channels.
package axi_pim_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // max_size is log2 of the bus width in bytes; wrap bursts must be 2/4/8/16 beats.
  function automatic logic legal_burst(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic [2:0] max_size);
    logic ok;
    ok = (size <= max_size) && (burst != 2'b11);
    if (burst == BURST_WRAP)
      ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return ok;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_pim_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Wrap window is (len+1) beats of 2**size bytes, aligned to its own size.
    wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_pim_banked_slave.sv
// AXI4 slave in front of NUM_BANKS PIM operand/result memories with independent
// read and write engines, full burst support, byte strobes and SLVERR reporting.
module axi_pim_banked_slave
  import axi_pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int         OFFS       = $clog2(STRB_WIDTH);
  localparam int         WORD_BITS  = ADDR_WIDTH - OFFS;
  localparam int         BANK_BITS  = $clog2(NUM_BANKS);
  localparam int         ROW_BITS   = WORD_BITS - BANK_BITS;
  localparam int         BANK_DEPTH = 2 ** ROW_BITS;
  localparam int         BSEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam logic [2:0] MAX_SIZE   = 3'(OFFS);

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

  // Bank is the top bits of the word index; a single bank always decodes to 0.
  function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    return BSEL_W'(a[ADDR_WIDTH-1:OFFS] >> ROW_BITS);
  endfunction

  function automatic logic [ROW_BITS-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFS +: ROW_BITS];
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

  // Write engine state
  wstate_e               wstate;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_next;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_last_bad;

  // Read engine state
  rstate_e               rstate;
  logic [ADDR_WIDTH-1:0] r_addr, r_next;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic w_beat, w_final, ar_legal;
  assign w_beat   = (wstate == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_final  = (w_cnt == w_len);
  assign ar_legal = legal_burst(s_axi_arlen, s_axi_arsize, s_axi_arburst, MAX_SIZE);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
  );

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
  );

  // NOTE: bank storage has no reset, so it maps onto plain RAM; only control state is cleared.
  always_ff @(posedge clock) begin
    if (w_beat && !w_err) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi_wstrb[b])
          mem[bank_of(w_addr)][row_of(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so same-edge reads see old values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
      w_last_bad    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awready && s_axi_awvalid) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= !legal_burst(s_axi_awlen, s_axi_awsize, s_axi_awburst, MAX_SIZE);
            w_last_bad    <= 1'b0;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            if (s_axi_wlast != w_final) w_last_bad <= 1'b1;
            // The beat counter, not wlast, decides when the burst ends.
            if (w_final) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err || w_last_bad || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arready && s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            r_err         <= !ar_legal;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            s_axi_rdata   <= ar_legal ? mem[bank_of(s_axi_araddr)][row_of(s_axi_araddr)] : '0;
            rstate        <= R_DATA;
          end
        end
        R_DATA: begin
          // Without rready every R output holds, keeping the presented beat stable.
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
              s_axi_rdata <= r_err ? '0 : mem[bank_of(r_next)][row_of(r_next)];
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_pim_banked_slave.sv
// Directed self-checking bench for axi_pim_banked_slave (4 banks, 32-bit data, 16-bit address).
module tb_axi_pim_banked_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_axi_awid = '0;
  logic [15:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awlock = 1'b0;
  logic [3:0]  s_axi_awcache = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_arid = '0;
  logic [15:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arlock = 1'b0;
  logic [3:0]  s_axi_arcache = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [7:0]  rd_id;
  int          rd_lat;
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  axi_pim_banked_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .NUM_BANKS(4)
  ) dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clock = ~clock;

  // Transaction driver: AW handshake, len+1 W beats from wr_data/wr_strb, then B.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] id, input bit bad_last);
    int n;
    @(negedge clock);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 64) begin @(negedge clock); n++; end
    if (!s_axi_awready) begin
      checks++; errors++;
      $display("FAIL write_aw_timeout addr=%h awready=%b required=1", addr, s_axi_awready);
      s_axi_awvalid = 1'b0;
      return;
    end
    @(negedge clock);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wr_data[i]; s_axi_wstrb = wr_strb[i];
      s_axi_wlast = bad_last ? 1'b0 : (i == int'(len));
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 64) begin @(negedge clock); n++; end
      if (!s_axi_wready) begin
        checks++; errors++;
        $display("FAIL write_w_timeout beat=%0d wready=%b required=1", i, s_axi_wready);
        s_axi_wvalid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 64) begin @(negedge clock); n++; end
    if (!s_axi_bvalid) begin
      checks++; errors++;
      $display("FAIL write_b_timeout bvalid=%b required=1", s_axi_bvalid);
    end
    b_resp = s_axi_bresp; b_id = s_axi_bid;
    @(negedge clock);
    s_axi_bready = 1'b0;
  endtask

  // Transaction driver: AR handshake then len+1 R beats with rready held high.
  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [7:0] id);
    int n;
    @(negedge clock);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 64) begin @(negedge clock); n++; end
    if (!s_axi_arready) begin
      checks++; errors++;
      $display("FAIL read_ar_timeout addr=%h arready=%b required=1", addr, s_axi_arready);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge clock);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_axi_rvalid && n < 64) begin @(negedge clock); n++; end
      if (!s_axi_rvalid) begin
        checks++; errors++;
        $display("FAIL read_r_timeout beat=%0d rvalid=%b required=1", i, s_axi_rvalid);
        s_axi_rready = 1'b0;
        return;
      end
      if (i == 0) rd_lat = n;
      rd_data[i] = s_axi_rdata; rd_resp[i] = s_axi_rresp;
      rd_last[i] = s_axi_rlast; rd_id = s_axi_rid;
      @(negedge clock);
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes got=%b required=000000",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast});
    end
    checks++;
    if ({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata} !== 52'h0) begin
      errors++;
      $display("FAIL reset_payload bid=%h bresp=%b rid=%h rresp=%b rdata=%h required=all zero",
               s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset awready=%b arready=%b required=1 1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_incr_write();
    wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
    wr_data[2] = 32'h33333333; wr_data[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
    do_write(16'h0010, 8'd3, 3'd2, 2'b01, 8'h5A, 1'b0);
    checks++;
    if (b_resp !== 2'b00 || b_id !== 8'h5A) begin
      errors++;
      $display("FAIL incr_write_b bresp=%b bid=%h required=00 5a", b_resp, b_id);
    end
    do_read(16'h0010, 8'd3, 3'd2, 2'b01, 8'h21);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== wr_data[i] || rd_resp[i] !== 2'b00) begin
        errors++;
        $display("FAIL incr_readback beat=%0d got=%h/%b required=%h/00", i, rd_data[i], rd_resp[i], wr_data[i]);
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp [4];
    exp[0] = 32'h44444444; exp[1] = 32'h11111111; exp[2] = 32'h22222222; exp[3] = 32'h33333333;
    do_read(16'h001C, 8'd3, 3'd2, 2'b10, 8'h3C);
    checks++;
    if (rd_lat !== 0) begin
      errors++;
      $display("FAIL wrap_first_latency extra_cycles=%0d required=0", rd_lat);
    end
    checks++;
    if (rd_id !== 8'h3C) begin
      errors++;
      $display("FAIL wrap_rid got=%h required=3c", rd_id);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
        errors++;
        $display("FAIL wrap_beat beat=%0d got=%h last=%b resp=%b required=%h last=%b resp=00",
                 i, rd_data[i], rd_last[i], rd_resp[i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    wr_data[0] = 32'h00000000; wr_strb[0] = 4'hF;
    do_write(16'h0000, 8'd0, 3'd2, 2'b01, 8'h01, 1'b0);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    do_write(16'h0000, 8'd0, 3'd2, 2'b01, 8'h02, 1'b0);
    checks++;
    if (b_resp !== 2'b00) begin
      errors++;
      $display("FAIL strobe_bresp got=%b required=00", b_resp);
    end
    do_read(16'h0000, 8'd0, 3'd2, 2'b01, 8'h03);
    checks++;
    if (rd_data[0] !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL strobe_merge got=%h required=00bb00dd", rd_data[0]);
    end
  endtask

  task automatic test_bank_map();
    wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
    do_write(16'hC000, 8'd0, 3'd2, 2'b01, 8'h04, 1'b0);
    checks++;
    if (dut.mem[3][0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bank3_row0 got=%h required=cafef00d", dut.mem[3][0]);
    end
    do_read(16'hC000, 8'd0, 3'd2, 2'b01, 8'h05);
    checks++;
    if (rd_data[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bank3_read got=%h required=cafef00d", rd_data[0]);
    end
    do_read(16'h0000, 8'd0, 3'd2, 2'b01, 8'h06);
    checks++;
    if (rd_data[0] !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL bank0_untouched got=%h required=00bb00dd", rd_data[0]);
    end
  endtask

  task automatic test_errors();
    wr_data[0] = 32'hDEADBEEF; wr_data[1] = 32'hDEADBEEF;
    wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(16'h0010, 8'd1, 3'd3, 2'b01, 8'h77, 1'b0);
    checks++;
    if (b_resp !== 2'b10 || b_id !== 8'h77) begin
      errors++;
      $display("FAIL oversize_write_b bresp=%b bid=%h required=10 77", b_resp, b_id);
    end
    do_read(16'h0010, 8'd0, 3'd2, 2'b01, 8'h08);
    checks++;
    if (rd_data[0] !== 32'h11111111) begin
      errors++;
      $display("FAIL oversize_write_suppressed got=%h required=11111111", rd_data[0]);
    end
    do_read(16'h0010, 8'd1, 3'd2, 2'b11, 8'h42);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL bad_burst_read beat=%0d got=%h resp=%b last=%b required=00000000 10 %b",
                 i, rd_data[i], rd_resp[i], rd_last[i], (i == 1));
      end
    end
    do_read(16'h0010, 8'd2, 3'd2, 2'b10, 8'h43);
    checks++;
    if (rd_data[2] !== 32'h0 || rd_resp[2] !== 2'b10 || rd_last[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_len2_read got=%h resp=%b last=%b required=00000000 10 1", rd_data[2], rd_resp[2], rd_last[2]);
    end
    wr_data[0] = 32'h55555555; wr_data[1] = 32'h66666666;
    do_write(16'h0080, 8'd1, 3'd2, 2'b01, 8'h09, 1'b1);
    checks++;
    if (b_resp !== 2'b10) begin
      errors++;
      $display("FAIL wlast_mismatch_bresp got=%b required=10", b_resp);
    end
    wr_data[0] = 32'h000000A1; wr_data[1] = 32'h000000B2; wr_data[2] = 32'h000000C3;
    wr_strb[2] = 4'hF;
    do_write(16'h0020, 8'd2, 3'd2, 2'b00, 8'h0A, 1'b0);
    do_read(16'h0020, 8'd0, 3'd2, 2'b01, 8'h0B);
    checks++;
    if (b_resp !== 2'b00 || rd_data[0] !== 32'h000000C3) begin
      errors++;
      $display("FAIL fixed_write bresp=%b data=%h required=00 000000c3", b_resp, rd_data[0]);
    end
  endtask

  task automatic test_rready_stall();
    logic [15:0] pat;
    logic [31:0] prev_data;
    logic        prev_valid, prev_ready, prev_last;
    int          beat, n;
    pat = 16'b1011_0100_1101_0110;
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = 32'h10000000 + i;
      wr_strb[i] = 4'hF;
    end
    do_write(16'h0100, 8'd7, 3'd2, 2'b01, 8'h0C, 1'b0);
    @(negedge clock);
    s_axi_arid = 8'h0D; s_axi_araddr = 16'h0100; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 64) begin @(negedge clock); n++; end
    @(negedge clock);
    s_axi_arvalid = 1'b0;
    beat = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 100 && beat < 8; c++) begin
      s_axi_rready = pat[c % 16];
      if (s_axi_rvalid) begin
        if (prev_valid && !prev_ready) begin
          checks++;
          if (s_axi_rdata !== prev_data || s_axi_rlast !== prev_last) begin
            errors++;
            $display("FAIL stall_hold beat=%0d got=%h/%b required=%h/%b", beat, s_axi_rdata, s_axi_rlast, prev_data, prev_last);
          end
        end
        if (s_axi_rready) begin
          checks++;
          if (s_axi_rdata !== (32'h10000000 + beat) || s_axi_rlast !== (beat == 7)) begin
            errors++;
            $display("FAIL stall_beat beat=%0d got=%h last=%b required=%h last=%b",
                     beat, s_axi_rdata, s_axi_rlast, 32'h10000000 + beat, (beat == 7));
          end
          beat++;
        end
      end
      prev_valid = s_axi_rvalid; prev_ready = s_axi_rready;
      prev_data = s_axi_rdata; prev_last = s_axi_rlast;
      @(negedge clock);
    end
    s_axi_rready = 1'b0;
    checks++;
    if (beat != 8 || s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_completion beats=%0d rvalid=%b required=8 0", beat, s_axi_rvalid);
    end
  endtask

  task automatic test_read_before_write();
    int n;
    wr_data[0] = 32'h0000AAAA; wr_strb[0] = 4'hF;
    do_write(16'h0040, 8'd0, 3'd2, 2'b01, 8'h0E, 1'b0);
    @(negedge clock);
    s_axi_awid = 8'h0F; s_axi_awaddr = 16'h0040; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 64) begin @(negedge clock); n++; end
    @(negedge clock);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_arid = 8'h10; s_axi_araddr = 16'h0040; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    checks++;
    if (s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_ready wready=%b arready=%b required=1 1", s_axi_wready, s_axi_arready);
    end
    @(negedge clock);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL read_before_write rvalid=%b rdata=%h required=1 0000aaaa", s_axi_rvalid, s_axi_rdata);
    end
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      errors++;
      $display("FAIL rbw_bresp bvalid=%b bresp=%b required=1 00", s_axi_bvalid, s_axi_bresp);
    end
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(negedge clock);
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    do_read(16'h0040, 8'd0, 3'd2, 2'b01, 8'h11);
    checks++;
    if (rd_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL rbw_new_value got=%h required=12345678", rd_data[0]);
    end
  endtask

  task automatic test_addr_wrap();
    wr_data[0] = 32'h0F0F0F0F; wr_data[1] = 32'h7E7E7E7E;
    wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(16'hFFFC, 8'd1, 3'd2, 2'b01, 8'h12, 1'b0);
    do_read(16'h0000, 8'd0, 3'd2, 2'b01, 8'h13);
    checks++;
    if (rd_data[0] !== 32'h7E7E7E7E) begin
      errors++;
      $display("FAIL incr_modulo_wrap got=%h required=7e7e7e7e", rd_data[0]);
    end
    do_read(16'hFFFC, 8'd0, 3'd2, 2'b01, 8'h14);
    checks++;
    if (rd_data[0] !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL top_word got=%h required=0f0f0f0f", rd_data[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(negedge clock);
    s_axi_awid = 8'h15; s_axi_awaddr = 16'h0200; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 64) begin @(negedge clock); n++; end
    @(negedge clock);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h99999999; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL mid_burst_reset got=%b required=00000",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready awready=%b wready=%b required=1 0", s_axi_awready, s_axi_wready);
    end
    wr_data[0] = 32'h5A5A0001; wr_strb[0] = 4'hF;
    do_write(16'h0300, 8'd0, 3'd2, 2'b01, 8'h16, 1'b0);
    do_read(16'h0300, 8'd0, 3'd2, 2'b01, 8'h17);
    checks++;
    if (b_resp !== 2'b00 || b_id !== 8'h16 || rd_data[0] !== 32'h5A5A0001) begin
      errors++;
      $display("FAIL post_reset_write bresp=%b bid=%h data=%h required=00 16 5a5a0001", b_resp, b_id, rd_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_incr_write();
    test_wrap_read();
    test_strobe();
    test_bank_map();
    test_errors();
    test_rready_stall();
    test_read_before_write();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
